biosignal_ram_writer: RTL and testbench

- Upstream stage of the shared data RAM's ADC write port.
- Accepts independent EMG and ECG sample strobes from the ADC front-ends and pairs them into one EMG/ECG sample set.
- Each set becomes a single dual-address write into two circular buffers in RAM.
- Detects write collisions with CPU stores, which win priority and silently drop ADC writes, and retries until each write lands; exposes a write index, sample count and overrun flag for firmware.

---
 rtl/biosignal_ram_writer_pkg.sv | 26 ++
 rtl/biosignal_ram_writer_if.sv | 41 ++++
 rtl/biosignal_sample_hold.sv | 55 +++++
 rtl/biosignal_ram_writer.sv | 129 ++++++++++++
 tb/tb_biosignal_ram_writer.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/biosignal_ram_writer_pkg.sv
// Shared constants, FSM state type and helpers for the biosignal RAM writer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package biosignal_pkg;

  // Defaults mirrored in the firmware headers; change both together.
  localparam int unsigned DEF_DATA_WIDTH    = 32;
  localparam int unsigned DEF_ADDRESS_WIDTH = 12;
  localparam int unsigned DEF_ADC_WIDTH     = 12;
  localparam int unsigned DEF_BUF_AW        = 9;
  localparam logic [11:0] DEF_EMG_BASE      = 12'h800;
  localparam logic [11:0] DEF_ECG_BASE      = 12'hA00;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    COMMIT  = 1'b1
  } state_e;

  // Keep the low w bits of v and clear the rest; callers cast to their own width.
  function automatic logic [63:0] zext(input logic [63:0] v, input int unsigned w);
    logic [63:0] mask;
    mask = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    return v & mask;
  endfunction

endpackage

// File: rtl/biosignal_ram_writer_if.sv
// Sample inputs, CPU collision observe and RAM ADC write port of the writer.
// Latency: n/a (wiring only).
// Backpressure: none on the strobes; the writer itself drops and flags overruns.
interface biosignal_ram_writer_if import biosignal_pkg::*; #(
  parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int unsigned ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int unsigned ADC_WIDTH     = DEF_ADC_WIDTH,
  parameter int unsigned BUF_AW        = DEF_BUF_AW
) ();

  logic                     enable;
  logic                     emg_valid;
  logic [ADC_WIDTH-1:0]     emg_sample;
  logic                     ecg_valid;
  logic [ADC_WIDTH-1:0]     ecg_sample;
  logic                     cpu_wEn;
  logic                     clear_overrun;
  logic                     adc_wEn;
  logic [ADDRESS_WIDTH-1:0] adc_addr_emg;
  logic [DATA_WIDTH-1:0]    adc_dataIn_emg;
  logic [ADDRESS_WIDTH-1:0] adc_addr_ecg;
  logic [DATA_WIDTH-1:0]    adc_dataIn_ecg;
  logic [BUF_AW-1:0]        wr_index;
  logic [DATA_WIDTH-1:0]    sample_count;
  logic                     overrun;

  // Writer side.
  modport slave (
    input  enable, emg_valid, emg_sample, ecg_valid, ecg_sample, cpu_wEn, clear_overrun,
    output adc_wEn, adc_addr_emg, adc_dataIn_emg, adc_addr_ecg, adc_dataIn_ecg,
           wr_index, sample_count, overrun
  );

  // ADC front-end / RAM / firmware side.
  modport master (
    output enable, emg_valid, emg_sample, ecg_valid, ecg_sample, cpu_wEn, clear_overrun,
    input  adc_wEn, adc_addr_emg, adc_dataIn_emg, adc_addr_ecg, adc_dataIn_ecg,
           wr_index, sample_count, overrun
  );

endinterface

// File: rtl/biosignal_sample_hold.sv
// One-entry sample hold register with pending flag and drop (overrun) detect.
// Latency: a strobe is visible on pending_nxt/sample_nxt in the same cycle, registered at the edge.
// Backpressure: none; a strobe while full is dropped and reported on drop.
module biosignal_sample_hold #(
  parameter int unsigned W = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         strobe,
  input  logic [W-1:0] sample_in,
  input  logic         consume,
  output logic         pending_nxt,
  output logic [W-1:0] sample_nxt,
  output logic         drop
);

  logic         pending_q, pending_d;
  logic [W-1:0] sample_q, sample_d;
  logic         accept;

  // Next-entry selection: a consuming cycle frees the slot so a same-cycle strobe refills it.
  always_comb begin
    accept    = strobe & enable;
    pending_d = pending_q;
    sample_d  = sample_q;
    drop      = 1'b0;
    if (consume) begin
      pending_d = accept;
      if (accept) sample_d = sample_in;
    end else if (accept) begin
      if (pending_q) begin
        drop = 1'b1;
      end else begin
        pending_d = 1'b1;
        sample_d  = sample_in;
      end
    end
  end

  // Entry registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= 1'b0;
      sample_q  <= '0;
    end else begin
      pending_q <= pending_d;
      sample_q  <= sample_d;
    end
  end

  assign pending_nxt = pending_d;
  assign sample_nxt  = sample_d;

endmodule

// File: rtl/biosignal_ram_writer.sv
// Pairs EMG/ECG samples and writes each pair into two circular RAM buffers, retrying on CPU collisions.
// Latency: second sample of a pair in cycle N drives adc_wEn in cycle N+1; index/count update when the write lands.
// Backpressure: CPU stores stall the write indefinitely; samples arriving while a channel is full are dropped and set overrun.
module biosignal_ram_writer import biosignal_pkg::*; #(
  parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int unsigned ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int unsigned ADC_WIDTH     = DEF_ADC_WIDTH,
  parameter int unsigned BUF_AW        = DEF_BUF_AW,
  parameter logic [ADDRESS_WIDTH-1:0] EMG_BASE = ADDRESS_WIDTH'(DEF_EMG_BASE),
  parameter logic [ADDRESS_WIDTH-1:0] ECG_BASE = ADDRESS_WIDTH'(DEF_ECG_BASE)
) (
  input  logic               clk,
  input  logic               reset,
  biosignal_ram_writer_if.slave bus
);

  localparam logic [ADDRESS_WIDTH-1:0] BUF_MASK = ADDRESS_WIDTH'((64'd1 << BUF_AW) - 64'd1);

  if ((EMG_BASE & BUF_MASK) != '0) begin : g_bad_emg_align
    $error("EMG_BASE must be aligned to the buffer depth");
  end
  if ((ECG_BASE & BUF_MASK) != '0) begin : g_bad_ecg_align
    $error("ECG_BASE must be aligned to the buffer depth");
  end
  if ((EMG_BASE >> BUF_AW) == (ECG_BASE >> BUF_AW)) begin : g_bad_overlap
    $error("EMG and ECG buffers overlap");
  end
  if (ADC_WIDTH > DATA_WIDTH || DATA_WIDTH > 64) begin : g_bad_width
    $error("ADC_WIDTH must not exceed DATA_WIDTH, DATA_WIDTH at most 64");
  end
  if (BUF_AW >= ADDRESS_WIDTH) begin : g_bad_aw
    $error("BUF_AW must be less than ADDRESS_WIDTH");
  end

  state_e                   state_q, state_d;
  logic [BUF_AW-1:0]        wr_index_q, wr_index_d;
  logic [DATA_WIDTH-1:0]    sample_count_q, sample_count_d;
  logic                     overrun_q, overrun_d;
  logic                     adc_wEn_q, adc_wEn_d;
  logic [ADDRESS_WIDTH-1:0] addr_emg_q, addr_emg_d, addr_ecg_q, addr_ecg_d;
  logic [DATA_WIDTH-1:0]    data_emg_q, data_emg_d, data_ecg_q, data_ecg_d;

  logic                 commit_done;
  logic                 emg_pending, ecg_pending, emg_drop, ecg_drop;
  logic [ADC_WIDTH-1:0] emg_held, ecg_held;

  // A commit lands only when the RAM did not give the cycle to a CPU store.
  assign commit_done = (state_q == COMMIT) && !bus.cpu_wEn;

  biosignal_sample_hold #(.W(ADC_WIDTH)) u_emg_hold (
    .clk(clk), .reset(reset), .enable(bus.enable), .strobe(bus.emg_valid),
    .sample_in(bus.emg_sample), .consume(commit_done),
    .pending_nxt(emg_pending), .sample_nxt(emg_held), .drop(emg_drop)
  );

  biosignal_sample_hold #(.W(ADC_WIDTH)) u_ecg_hold (
    .clk(clk), .reset(reset), .enable(bus.enable), .strobe(bus.ecg_valid),
    .sample_in(bus.ecg_sample), .consume(commit_done),
    .pending_nxt(ecg_pending), .sample_nxt(ecg_held), .drop(ecg_drop)
  );

  // Next state, bookkeeping and registered write-port values (outputs come straight from flops).
  always_comb begin
    state_d        = state_q;
    wr_index_d     = wr_index_q;
    sample_count_d = sample_count_q;
    case (state_q)
      COLLECT: if (emg_pending && ecg_pending) state_d = COMMIT;
      COMMIT: begin
        if (commit_done) begin
          state_d        = COLLECT;
          wr_index_d     = wr_index_q + BUF_AW'(1);
          sample_count_d = sample_count_q + DATA_WIDTH'(1);
        end
      end
      default: state_d = COLLECT;
    endcase

    // Set wins over a same-cycle clear so a drop is never lost.
    overrun_d = (emg_drop || ecg_drop) ? 1'b1 : (bus.clear_overrun ? 1'b0 : overrun_q);

    adc_wEn_d  = (state_d == COMMIT);
    addr_emg_d = '0;
    addr_ecg_d = '0;
    data_emg_d = '0;
    data_ecg_d = '0;
    if (state_d == COMMIT) begin
      addr_emg_d = EMG_BASE | ADDRESS_WIDTH'(wr_index_d);
      addr_ecg_d = ECG_BASE | ADDRESS_WIDTH'(wr_index_d);
      data_emg_d = DATA_WIDTH'(zext(64'(emg_held), ADC_WIDTH));
      data_ecg_d = DATA_WIDTH'(zext(64'(ecg_held), ADC_WIDTH));
    end
  end

  // State and output registers; reset abandons any in-flight write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= COLLECT;
      wr_index_q     <= '0;
      sample_count_q <= '0;
      overrun_q      <= 1'b0;
      adc_wEn_q      <= 1'b0;
      addr_emg_q     <= '0;
      addr_ecg_q     <= '0;
      data_emg_q     <= '0;
      data_ecg_q     <= '0;
    end else begin
      state_q        <= state_d;
      wr_index_q     <= wr_index_d;
      sample_count_q <= sample_count_d;
      overrun_q      <= overrun_d;
      adc_wEn_q      <= adc_wEn_d;
      addr_emg_q     <= addr_emg_d;
      addr_ecg_q     <= addr_ecg_d;
      data_emg_q     <= data_emg_d;
      data_ecg_q     <= data_ecg_d;
    end
  end

  assign bus.adc_wEn        = adc_wEn_q;
  assign bus.adc_addr_emg   = addr_emg_q;
  assign bus.adc_addr_ecg   = addr_ecg_q;
  assign bus.adc_dataIn_emg = data_emg_q;
  assign bus.adc_dataIn_ecg = data_ecg_q;
  assign bus.wr_index       = wr_index_q;
  assign bus.sample_count   = sample_count_q;
  assign bus.overrun        = overrun_q;

endmodule

// File: tb/tb_biosignal_ram_writer.sv
// Bench for biosignal_ram_writer: vector table, hand-written corner sequences, random vs. reference model.
// Latency: outputs checked 1 time unit after each rising edge.
// Backpressure: driven via cpu_wEn collisions and repeated strobes.
module tb_biosignal_ram_writer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  biosignal_ram_writer_if bus ();
  biosignal_ram_writer dut (.clk(clk), .reset(reset), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a pair is "in flight" until a cycle without CPU store; slot = count mod 512.
  logic [31:0] m_cnt;
  logic        m_busy, m_eh, m_ch, m_ov;
  logic [11:0] m_ev, m_cv;

  function automatic void model(input logic rst, en, ev, input logic [11:0] es,
                                input logic cv, input logic [11:0] cs, input logic cpu, clr);
    logic was, ovr_ev;
    if (rst) begin
      m_cnt = 0; m_busy = 0; m_eh = 0; m_ch = 0; m_ov = 0; m_ev = 0; m_cv = 0;
      return;
    end
    was    = m_busy;
    ovr_ev = 0;
    if (was && !cpu) begin
      m_cnt  = m_cnt + 1;
      m_busy = 0;
      m_eh   = 0;
      m_ch   = 0;
    end
    if (en && ev) begin
      if (m_eh) ovr_ev = 1; else begin m_eh = 1; m_ev = es; end
    end
    if (en && cv) begin
      if (m_ch) ovr_ev = 1; else begin m_ch = 1; m_cv = cs; end
    end
    if (ovr_ev) m_ov = 1; else if (clr) m_ov = 0;
    if (!was && m_eh && m_ch) m_busy = 1;
  endfunction

  task automatic cyc(input logic rst, en, ev, input logic [11:0] es,
                     input logic cv, input logic [11:0] cs, input logic cpu, clr);
    reset             = rst;
    bus.enable        = en;
    bus.emg_valid     = ev;
    bus.emg_sample    = es;
    bus.ecg_valid     = cv;
    bus.ecg_sample    = cs;
    bus.cpu_wEn       = cpu;
    bus.clear_overrun = clr;
    @(posedge clk);
    model(rst, en, ev, es, cv, cs, cpu, clr);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic wen, input logic [11:0] ae, ac,
                           input logic [31:0] de, dc, input logic [8:0] wi,
                           input logic [31:0] cnt, input logic ov);
    chk({tag, ".adc_wEn"},   32'(bus.adc_wEn),      32'(wen));
    chk({tag, ".addr_emg"},  32'(bus.adc_addr_emg), 32'(ae));
    chk({tag, ".addr_ecg"},  32'(bus.adc_addr_ecg), 32'(ac));
    chk({tag, ".data_emg"},  bus.adc_dataIn_emg,    de);
    chk({tag, ".data_ecg"},  bus.adc_dataIn_ecg,    dc);
    chk({tag, ".wr_index"},  32'(bus.wr_index),     32'(wi));
    chk({tag, ".count"},     bus.sample_count,      cnt);
    chk({tag, ".overrun"},   32'(bus.overrun),      32'(ov));
  endtask

  typedef struct {
    logic        en, ev;
    logic [11:0] es;
    logic        cv;
    logic [11:0] cs;
    logic        cpu, clr;
    logic        wen;
    logic [11:0] ae, ac;
    logic [31:0] de, dc;
    logic [8:0]  wi;
    logic [31:0] cnt;
    logic        ov;
  } vec_t;

  vec_t tbl[23];

  initial begin
    logic        wen_e;
    logic [11:0] ae_e, ac_e;
    logic [31:0] de_e, dc_e;

    // en ev es cv cs cpu clr | wen ae ac de dc wi cnt ov
    tbl[0]  = '{1,1,'h123,1,'h456,0,0, 1,'h800,'hA00,'h123,'h456,0,0,0}; // basic pair
    tbl[1]  = '{1,0,0,0,0,0,0,         0,0,0,0,0,1,1,0};
    tbl[2]  = '{1,1,'h0AA,0,0,0,0,     0,0,0,0,0,1,1,0};                 // late pair: EMG first
    tbl[3]  = '{1,0,0,0,0,0,0,         0,0,0,0,0,1,1,0};
    tbl[4]  = '{1,0,0,0,0,0,0,         0,0,0,0,0,1,1,0};
    tbl[5]  = '{1,0,0,0,0,0,0,         0,0,0,0,0,1,1,0};
    tbl[6]  = '{1,0,0,0,0,0,0,         0,0,0,0,0,1,1,0};
    tbl[7]  = '{1,0,0,1,'h0BB,0,0,     1,'h801,'hA01,'h0AA,'h0BB,1,1,0}; // ECG 5 cycles later
    tbl[8]  = '{1,0,0,0,0,1,0,         1,'h801,'hA01,'h0AA,'h0BB,1,1,0}; // collision 1
    tbl[9]  = '{1,0,0,0,0,1,0,         1,'h801,'hA01,'h0AA,'h0BB,1,1,0}; // collision 2
    tbl[10] = '{1,0,0,0,0,0,0,         0,0,0,0,0,2,2,0};                 // lands once
    tbl[11] = '{1,1,'h001,0,0,0,0,     0,0,0,0,0,2,2,0};
    tbl[12] = '{1,1,'h002,0,0,0,0,     0,0,0,0,0,2,2,1};                 // overrun
    tbl[13] = '{1,0,0,1,'h0CC,0,0,     1,'h802,'hA02,'h001,'h0CC,2,2,1}; // first EMG kept
    tbl[14] = '{1,0,0,0,0,0,1,         0,0,0,0,0,3,3,0};                 // clear
    tbl[15] = '{1,1,'h010,0,0,0,0,     0,0,0,0,0,3,3,0};
    tbl[16] = '{1,1,'h011,0,0,0,1,     0,0,0,0,0,3,3,1};                 // set beats clear
    tbl[17] = '{1,0,0,0,0,0,1,         0,0,0,0,0,3,3,0};
    tbl[18] = '{0,0,0,1,'h0DD,0,0,     0,0,0,0,0,3,3,0};                 // enable=0 ignores
    tbl[19] = '{1,0,0,1,'h0DD,0,0,     1,'h803,'hA03,'h010,'h0DD,3,3,0};
    tbl[20] = '{1,1,'h020,1,'h021,0,0, 0,0,0,0,0,4,4,0};                 // strobes on commit
    tbl[21] = '{1,0,0,0,0,0,0,         1,'h804,'hA04,'h020,'h021,4,4,0};
    tbl[22] = '{1,0,0,0,0,0,0,         0,0,0,0,0,5,5,0};

    model(1'b1, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    bus.enable = 0; bus.emg_valid = 0; bus.emg_sample = 0; bus.ecg_valid = 0;
    bus.ecg_sample = 0; bus.cpu_wEn = 0; bus.clear_overrun = 0;
    @(posedge clk); #1;
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    check_all("reset", 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 23; i++) begin
      cyc(0, tbl[i].en, tbl[i].ev, tbl[i].es, tbl[i].cv, tbl[i].cs, tbl[i].cpu, tbl[i].clr);
      check_all($sformatf("vec%0d", i), tbl[i].wen, tbl[i].ae, tbl[i].ac,
                tbl[i].de, tbl[i].dc, tbl[i].wi, tbl[i].cnt, tbl[i].ov);
    end

    // Buffer wrap: 512 pairs bring wr_index back to 0, pair 513 reuses the base addresses.
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    for (int p = 0; p < 512; p++) begin
      cyc(0, 1, 1, 12'(p), 1, 12'(p + 7), 0, 0);
      cyc(0, 1, 0, 0, 0, 0, 0, 0);
    end
    check_all("wrap", 0, 0, 0, 0, 0, 0, 512, 0);
    cyc(0, 1, 1, 12'h3AB, 1, 12'hFFF, 0, 0);
    check_all("pair513", 1, 'h800, 'hA00, 'h3AB, 'hFFF, 0, 512, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    check_all("pair513_done", 0, 0, 0, 0, 0, 1, 513, 0);

    // Reset while a write is stalled in COMMIT.
    cyc(0, 1, 1, 12'h055, 1, 12'h066, 0, 0);
    check_all("pre_rst", 1, 'h801, 'hA01, 'h055, 'h066, 1, 513, 0);
    cyc(1, 1, 0, 0, 0, 0, 1, 0);
    check_all("mid_rst", 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 12'h077, 1, 12'h088, 0, 0);
    check_all("post_rst", 1, 'h800, 'hA00, 'h077, 'h088, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    check_all("post_rst_done", 0, 0, 0, 0, 0, 1, 1, 0);

    // Random traffic against the reference model.
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 3000; c++) begin
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 7) != 0,
          $urandom_range(0, 3) == 0, 12'($urandom_range(0, 4095)),
          $urandom_range(0, 3) == 0, 12'($urandom_range(0, 4095)),
          $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
      wen_e = m_busy;
      ae_e  = m_busy ? 12'('h800 + (m_cnt % 512)) : 12'h0;
      ac_e  = m_busy ? 12'('hA00 + (m_cnt % 512)) : 12'h0;
      de_e  = m_busy ? 32'(m_ev) : 32'h0;
      dc_e  = m_busy ? 32'(m_cv) : 32'h0;
      check_all($sformatf("rnd%0d", c), wen_e, ae_e, ac_e, de_e, dc_e,
                9'(m_cnt % 512), m_cnt, m_ov);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
